arbitro_memoria_video: RTL and testbench
========================================

Name: arbitro_memoria_video

Overview:
- Sits directly upstream of controlador_vga and owns the single-port frame RAM.
- Serves the controller's 18-bit pixel address and returns the 8-bit data_drom byte.
- Accepts processed-image pixel writes from the processor side through a valid/ready stream.
- Buffers writes in a small FIFO and drains them into the RAM only while the display is blanked (n_blank low).
- Video reads always win during active display.

Parameters:
- ADDR_W, 18, frame RAM address width (matches controller address).
- DATA_W, 8, pixel byte width.
- DEPTH, 8, write FIFO depth in entries; must be a power of 2, minimum 2.

Ports:
- clock_25  in  1  pixel clock, 25 MHz, the only clock.
- reset  in  1  asynchronous, active-low reset.
- n_blank  in  1  active-video flag from sincronizador; 1 means visible pixel.
- vga_address  in  ADDR_W  pixel address from controlador_vga.
- data_drom  out  DATA_W  pixel byte to controlador_vga.
- wr_valid  in  1  write request from processor side.
- wr_ready  out  1  FIFO can accept a write this cycle.
- wr_address  in  ADDR_W  target RAM address of the write.
- wr_data  in  DATA_W  pixel byte to write.
- mem_address  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data; synchronous, valid 1 cycle after address.
- pendientes  out  $clog2(DEPTH)+1  current FIFO occupancy.
- pixeles_escritos  out  ADDR_W  count of writes committed to RAM; wraps modulo 2^ADDR_W.
- vaciado  out  1  one-cycle pulse when a drain empties the FIFO.

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; pendientes=0, pixeles_escritos=0.
  - mem_we=0, data_drom=0, vaciado=0.
  - State is VIDEO; wr_ready=0 while reset is asserted.
  - After release, wr_ready=1 on the first clock.
  - A reset mid-drain drops all pending entries. No partial write is issued after reset asserts; mem_we falls immediately.
- Handshake:
  - Push occurs when wr_valid & wr_ready at the clock edge.
  - wr_ready = (pendientes < DEPTH), combinational from registered occupancy.
  - When full, wr_ready=0 even if a pop happens in the same cycle; there is no pass-through.
  - The processor must hold wr_address and wr_data stable while wr_valid=1 and wr_ready=0.
- State machine, evaluated each cycle on the current n_blank:
  - VIDEO (n_blank=1): mem_address=vga_address, mem_we=0, no pop.
    - To IDLE when n_blank=0 and FIFO empty.
    - To DRAIN when n_blank=0 and FIFO non-empty.
  - IDLE (n_blank=0, FIFO empty): mem_address=vga_address, mem_we=0.
    - To DRAIN when FIFO becomes non-empty.
    - To VIDEO when n_blank=1.
  - DRAIN (n_blank=0, FIFO non-empty): mem_address/mem_wdata = FIFO head, mem_we=1, pop on the clock edge, pixeles_escritos+1.
    - When the pop leaves the FIFO empty (no push that cycle): vaciado=1 next cycle, go to IDLE.
    - To VIDEO when n_blank=1.
- RAM port muxing:
  - The mux is combinational on n_blank: in any cycle with n_blank=1, mem_we=0 and mem_address=vga_address, regardless of registered state.
  - A write is never issued in an active-video cycle.
- One write per blanked cycle. Simultaneous push and pop leaves pendientes unchanged.
- Read path:
  - A registered flag records whether the previous cycle was a read.
  - data_drom = mem_rdata when that flag is 1, else 0.
  - Total latency from vga_address to data_drom is 1 cycle, identical to a plain ROM.
- Ordering:
  - Writes commit in FIFO order.
  - Two writes to the same address: the last one wins.
- Counter widths:
  - pendientes saturates only via wr_ready and never exceeds DEPTH.
  - pixeles_escritos wraps 2^ADDR_W-1 -> 0 without a flag.

Decomposition:
- Package pkg_video:
  - ADDR_W=18, DATA_W=8.
  - typedef enum estado_arb_t {VIDEO, IDLE, DRAIN}.
  - typedef struct wr_entry_t {addr, data}.
- One sub-module, fifo_escritura:
  - Parameterised DEPTH, holds wr_entry_t.
  - Ports: push, pop, head, count, full, empty.
  - Circular buffer with wrapping read/write pointers.

Test Plan:
- Reset release with n_blank=1 -> wr_ready=1, pendientes=0, mem_we=0; data_drom=0 until the first read completes, then equals RAM[vga_address] one cycle later.
- Push 3 writes (addr 0x00010/0x00011/0x00012, data 0xA1/0xA2/0xA3) while n_blank=1, then n_blank=0 -> mem_we high exactly 3 consecutive cycles in order, pixeles_escritos=3, vaciado pulses once, pendientes=0.
- Push DEPTH+2 writes with n_blank=1 -> wr_ready drops after 8 accepts, pendientes=8, held entries are not lost; after blanking all 8 commit and the last 2 are accepted as space frees.
- n_blank rises while 5 entries are pending -> mem_we=0 in that same cycle, data_drom follows vga_address; remaining entries commit in the next blanking interval.
- Two writes to 0x3FFFF (0x11, then 0x22) across blanking -> a read of 0x3FFFF returns 0x22; pixeles_escritos wraps correctly when preset near 2^18-1.
- Assert reset mid-DRAIN with 4 pending -> mem_we=0 immediately, pendientes=0, no further writes after release.

Source files
------------

// File: rtl/arbitro_memoria_video_pkg.sv
// ---------------------------------------------------------------------------
// pkg_video
//   Shared types for the frame RAM arbiter in front of controlador_vga.
//   ADDR_W / DATA_W : frame RAM address and pixel byte widths.
//   estado_arb_t    : arbiter state (VIDEO, IDLE, DRAIN).
//   wr_entry_t      : one buffered pixel write (address + data).
// ---------------------------------------------------------------------------
package pkg_video;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        VIDEO = 2'd0,
        IDLE  = 2'd1,
        DRAIN = 2'd2
    } estado_arb_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/arbitro_memoria_video_fifo_escritura.sv
// ---------------------------------------------------------------------------
// fifo_escritura
//   Circular buffer of pending pixel writes. DEPTH must be a power of two so
//   the pointers wrap on their own.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, din_i  : store din_i at the tail (caller guarantees !full_o)
//   pop_i          : drop the head entry (caller guarantees !empty_o)
//   head_o         : oldest entry
//   count_o        : occupancy 0..DEPTH
//   full_o/empty_o : occupancy flags
// ---------------------------------------------------------------------------
module fifo_escritura
    import pkg_video::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  wr_entry_t                din_i,
    input  logic                     pop_i,
    output wr_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

    wr_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_C);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/arbitro_memoria_video.sv
// ---------------------------------------------------------------------------
// arbitro_memoria_video
//   Owns the single-port frame RAM. Video reads from controlador_vga always
//   win while n_blank=1; processor writes are buffered in a FIFO and drained
//   one per cycle only while the display is blanked.
//   clock_25, reset      : pixel clock, asynchronous active-low reset
//   n_blank              : 1 = visible pixel
//   vga_address/data_drom: video read port, 1-cycle latency like a ROM
//   wr_valid/wr_ready/wr_address/wr_data : write stream from the processor
//   mem_address/mem_wdata/mem_we/mem_rdata : RAM port (sync read)
//   pendientes           : FIFO occupancy
//   pixeles_escritos     : writes committed to RAM, wraps silently
//   vaciado              : one-cycle pulse after a drain empties the FIFO
// ---------------------------------------------------------------------------
module arbitro_memoria_video #(
    parameter int ADDR_W = pkg_video::ADDR_W,
    parameter int DATA_W = pkg_video::DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                    clock_25,
    input  logic                    reset,
    input  logic                    n_blank,
    input  logic [ADDR_W-1:0]       vga_address,
    output logic [DATA_W-1:0]       data_drom,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_address,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    mem_we,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [$clog2(DEPTH):0]  pendientes,
    output logic [ADDR_W-1:0]       pixeles_escritos,
    output logic                    vaciado
);

    import pkg_video::*;

    localparam int CW = $clog2(DEPTH) + 1;

    estado_arb_t       state_q, state_d;
    logic              push, drain_act;
    logic              full, empty;
    logic [CW-1:0]     count;
    wr_entry_t         entry_in, head;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic              vac_q, vac_d;
    logic              rd_flag_q;

    // Gated by reset so the processor sees "not ready" throughout reset.
    assign wr_ready = reset & ~full;
    assign push     = wr_valid & wr_ready;

    // Narrower instances zero-extend into the shared entry type.
    always_comb begin
        entry_in = '0;
        entry_in.addr[ADDR_W-1:0] = wr_address;
        entry_in.data[DATA_W-1:0] = wr_data;
    end

    fifo_escritura #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock_25),
        .rst_n_i (reset),
        .push_i  (push),
        .din_i   (entry_in),
        .pop_i   (drain_act),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q   <= VIDEO;
            pix_q     <= '0;
            vac_q     <= 1'b0;
            rd_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            vac_q     <= vac_d;
            rd_flag_q <= ~mem_we;
        end
    end

    // A write only happens in DRAIN and is vetoed combinationally by n_blank,
    // so the first visible pixel never sees a write even before the state
    // register catches up.
    always_comb begin
        state_d   = state_q;
        drain_act = 1'b0;
        case (state_q)
            VIDEO: begin
                if (!n_blank) state_d = empty ? IDLE : DRAIN;
            end
            IDLE: begin
                if (n_blank)     state_d = VIDEO;
                else if (!empty) state_d = DRAIN;
            end
            DRAIN: begin
                if (n_blank) begin
                    state_d = VIDEO;
                end else begin
                    drain_act = ~empty;
                    // Last entry leaves with nothing arriving behind it.
                    if (empty || (count == CW'(1) && !push)) state_d = IDLE;
                end
            end
            default: state_d = VIDEO;
        endcase
    end

    always_comb begin
        pix_d = pix_q;
        vac_d = 1'b0;
        if (drain_act) begin
            pix_d = pix_q + ADDR_W'(1);
            vac_d = (count == CW'(1)) && !push;
        end
    end

    assign mem_we           = drain_act;
    assign mem_address      = drain_act ? head.addr[ADDR_W-1:0] : vga_address;
    assign mem_wdata        = head.data[DATA_W-1:0];
    // Write cycles return no read data, so the byte is masked off afterwards.
    assign data_drom        = rd_flag_q ? mem_rdata : '0;
    assign pendientes       = count;
    assign pixeles_escritos = pix_q;
    assign vaciado          = vac_q;

endmodule

// File: tb/tb_arbitro_memoria_video.sv
module tb_arbitro_memoria_video;

    logic        clk = 1'b0;
    logic        reset;
    logic        n_blank;
    logic [17:0] vga_address;
    logic [7:0]  data_drom;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] wr_address;
    logic [7:0]  wr_data;
    logic [17:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [3:0]  pendientes;
    logic [17:0] pixeles_escritos;
    logic        vaciado;

    // Small instance for pointer/counter wrap checks.
    logic        s_nb, s_wv, s_wr_ready, s_we, s_vac;
    logic [3:0]  s_wa, s_vga, s_maddr, s_pix;
    logic [7:0]  s_wd, s_drom, s_mwd;
    logic [1:0]  s_pend;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arbitro_memoria_video u_dut (
        .clock_25(clk), .reset(reset), .n_blank(n_blank),
        .vga_address(vga_address), .data_drom(data_drom),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_address(wr_address), .wr_data(wr_data),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .pendientes(pendientes),
        .pixeles_escritos(pixeles_escritos), .vaciado(vaciado)
    );

    arbitro_memoria_video #(.ADDR_W(4), .DEPTH(2)) u_small (
        .clock_25(clk), .reset(reset), .n_blank(s_nb),
        .vga_address(s_vga), .data_drom(s_drom),
        .wr_valid(s_wv), .wr_ready(s_wr_ready),
        .wr_address(s_wa), .wr_data(s_wd),
        .mem_address(s_maddr), .mem_wdata(s_mwd), .mem_we(s_we),
        .mem_rdata(8'h00), .pendientes(s_pend),
        .pixeles_escritos(s_pix), .vaciado(s_vac)
    );

    // RAM model: unwritten locations hold a fixed address-derived pattern.
    bit [7:0] ram   [0:262143];
    bit       wflag [0:262143];

    function automatic logic [7:0] init_byte(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_address]   <= mem_wdata;
            wflag[mem_address] <= 1'b1;
        end
        mem_rdata <= wflag[mem_address] ? ram[mem_address] : init_byte(mem_address);
    end

    // Monitor: commit log, vaciado pulses, writes during active video.
    logic [17:0] log_a [$];
    logic [7:0]  log_d [$];
    int          log_c [$];
    int          cyc_n    = 0;
    int          vac_cnt  = 0;
    int          we_viol  = 0;

    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (mem_we) begin
            log_a.push_back(mem_address);
            log_d.push_back(mem_wdata);
            log_c.push_back(cyc_n);
        end
        if (vaciado) vac_cnt <= vac_cnt + 1;
        if ((mem_we && n_blank) || (s_we && s_nb)) we_viol <= we_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [17:0] a, input logic [7:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_address = a; wr_data = d;
        while (!wr_ready && n < 100) begin cyc(); n++; end
        chk("push_accept", 32'(n < 100), 1);
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic check_log(input string tag, input int base, input int k,
                             input logic [17:0] a, input logic [7:0] d);
        chk({tag, "_addr"}, (base + k < log_a.size()) ? log_a[base+k] : 18'h3DEAD, a);
        chk({tag, "_data"}, (base + k < log_d.size()) ? log_d[base+k] : 8'hEE, d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, v0;
        reset = 1'b0; n_blank = 1'b1; vga_address = '0;
        wr_valid = 1'b0; wr_address = '0; wr_data = '0;
        s_nb = 1'b1; s_wv = 1'b0; s_wa = '0; s_wd = '0; s_vga = '0;

        // --- reset state
        #1;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_drom", data_drom, 0);
        chk("rst_pend", pendientes, 0);
        chk("rst_pix", pixeles_escritos, 0);
        chk("rst_vaciado", vaciado, 0);
        cyc(); cyc();
        reset = 1'b1;
        #1;
        chk("rel_wr_ready", wr_ready, 1);
        chk("rel_drom_zero", data_drom, 0);
        vga_address = 18'h00100;
        cyc();
        chk("first_read", data_drom, init_byte(18'h00100));

        // --- three writes, then one blanking interval
        base = log_a.size(); v0 = vac_cnt;
        push_one(18'h00010, 8'hA1);
        push_one(18'h00011, 8'hA2);
        push_one(18'h00012, 8'hA3);
        chk("t2_pend3", pendientes, 3);
        n_blank = 1'b0;
        repeat (6) cyc();
        chk("t2_nwrites", log_a.size() - base, 3);
        check_log("t2_w0", base, 0, 18'h00010, 8'hA1);
        check_log("t2_w1", base, 1, 18'h00011, 8'hA2);
        check_log("t2_w2", base, 2, 18'h00012, 8'hA3);
        chk("t2_consecutive", (log_c.size() >= base + 3) ? log_c[base+2] - log_c[base] : -1, 2);
        chk("t2_pix", pixeles_escritos, 3);
        chk("t2_vaciado", vac_cnt - v0, 1);
        chk("t2_pend0", pendientes, 0);
        n_blank = 1'b1; vga_address = 18'h00011;
        cyc();
        chk("t2_readback", data_drom, 8'hA2);

        // --- overflow: DEPTH+2 writes
        base = log_a.size(); v0 = vac_cnt;
        for (int i = 0; i < 8; i++) push_one(18'h00100 + 18'(i), 8'h30 + 8'(i));
        chk("t3_pend8", pendientes, 8);
        chk("t3_full_ready", wr_ready, 0);
        fork
            begin
                push_one(18'h00108, 8'h38);
                push_one(18'h00109, 8'h39);
            end
            begin
                cyc(); cyc();
                chk("t3_held_pend", pendientes, 8);
                chk("t3_held_ready", wr_ready, 0);
                n_blank = 1'b0;
            end
        join
        repeat (12) cyc();
        chk("t3_nwrites", log_a.size() - base, 10);
        for (int i = 0; i < 10; i++)
            check_log("t3_w", base, i, 18'h00100 + 18'(i), 8'h30 + 8'(i));
        chk("t3_pix", pixeles_escritos, 13);
        chk("t3_vaciado", vac_cnt - v0, 1);
        chk("t3_pend0", pendientes, 0);

        // --- unblank with 5 pending
        n_blank = 1'b1;
        cyc();
        base = log_a.size();
        for (int i = 0; i < 5; i++) push_one(18'h00200 + 18'(i), 8'h50 + 8'(i));
        n_blank = 1'b0;
        cyc(); cyc(); cyc();
        chk("t4_pend3", pendientes, 3);
        n_blank = 1'b1; vga_address = 18'h00011;
        #1;
        chk("t4_we_same_cycle", mem_we, 0);
        chk("t4_addr_same_cycle", mem_address, 18'h00011);
        cyc();
        chk("t4_drom", data_drom, 8'hA2);
        repeat (3) cyc();
        chk("t4_pend_hold", pendientes, 3);
        chk("t4_partial", log_a.size() - base, 2);
        n_blank = 1'b0;
        repeat (6) cyc();
        chk("t4_nwrites", log_a.size() - base, 5);
        for (int i = 0; i < 5; i++)
            check_log("t4_w", base, i, 18'h00200 + 18'(i), 8'h50 + 8'(i));
        chk("t4_pix", pixeles_escritos, 18);

        // --- same address twice, across blanking intervals
        n_blank = 1'b1;
        push_one(18'h3FFFF, 8'h11);
        n_blank = 1'b0; repeat (4) cyc();
        n_blank = 1'b1;
        push_one(18'h3FFFF, 8'h22);
        n_blank = 1'b0; repeat (4) cyc();
        n_blank = 1'b1; vga_address = 18'h3FFFF;
        cyc();
        chk("t5_last_wins", data_drom, 8'h22);
        chk("t5_pix", pixeles_escritos, 20);

        // --- small instance: full flag and counter wrap (17 writes, 4-bit count)
        for (int i = 0; i < 2; i++) begin
            s_wv = 1'b1; s_wa = 4'(i); s_wd = 8'(i);
            cyc();
        end
        s_wv = 1'b0;
        chk("sm_full_ready", s_wr_ready, 0);
        chk("sm_full_pend", s_pend, 2);
        s_nb = 1'b0;
        for (int i = 2; i < 17; i++) begin
            int n = 0;
            s_wv = 1'b1; s_wa = 4'(i); s_wd = 8'(i);
            while (!s_wr_ready && n < 50) begin cyc(); n++; end
            if (n >= 50) chk("sm_push_accept", 32'(n), 0);
            cyc();
        end
        s_wv = 1'b0;
        repeat (6) cyc();
        chk("sm_pix_wrap", s_pix, 1);
        chk("sm_pend0", s_pend, 0);

        // --- reset mid-drain with 4 pending
        n_blank = 1'b1;
        for (int i = 0; i < 4; i++) push_one(18'h00300 + 18'(i), 8'h70 + 8'(i));
        n_blank = 1'b0;
        cyc();
        #1;
        chk("t6_draining", mem_we, 1);
        base = log_a.size();
        reset = 1'b0;
        #1;
        chk("t6_we_drop", mem_we, 0);
        chk("t6_pend0", pendientes, 0);
        chk("t6_ready0", wr_ready, 0);
        cyc(); cyc();
        reset = 1'b1;
        repeat (6) cyc();
        chk("t6_no_writes", log_a.size() - base, 0);
        chk("t6_pix0", pixeles_escritos, 0);
        chk("t6_ram_untouched", ram[18'h00300] | {7'd0, ~wflag[18'h00300]}, 8'h01);

        chk("no_write_in_video", we_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
